// File: rtl/board_io_pkg.sv
// board_io_pkg: shared definitions for the board's push-button front-ends.
//   - debounce FSM state encoding
//   - default board timing constants (100 MHz clock)
//   - small constant helper used for counter sizing
package board_io_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_e;

  localparam int CLK_HZ        = 100_000_000;
  localparam int DEBOUNCE_10MS = CLK_HZ / 100;
  localparam int HOLD_1S       = CLK_HZ;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff: STAGES-deep flop chain bringing an asynchronous input into clk.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset, chain clears to 0
//   d_i  - asynchronous input
//   q_o  - synchronised output (last flop of the chain)
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: synchronises a raw bouncing push-button and filters it
// with a counter-based debounce FSM. Produces a clean level and one-cycle
// press/release pulses (all registered).
// Optional hold detection is built when macro LONG_PRESS_EN is defined;
// otherwise long_press is tied to 0.
// Ports:
//   clk           - clock
//   rst           - asynchronous active-high reset
//   btn_in        - raw asynchronous button, active-high
//   btn_level     - debounced level
//   press_pulse   - one-cycle pulse on accepted press
//   release_pulse - one-cycle pulse on accepted release
//   long_press    - one-cycle pulse after LONG_PRESS_CNT cycles held
module button_debouncer
  import board_io_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_CNT   = DEBOUNCE_10MS,
  parameter int LONG_PRESS_CNT = HOLD_1S
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam int CNT_W = $clog2(max_int(DEBOUNCE_CNT, LONG_PRESS_CNT) + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic btn_sync;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (btn_in),
    .q_o (btn_sync)
  );

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Counter is cleared on every state change, so it can never wrap.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn_sync) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!btn_sync) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_sync) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

`ifdef LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_PRESS_CNT - 1);
  localparam logic [CNT_W-1:0] LP_SAT  = CNT_W'(LONG_PRESS_CNT);

  logic [CNT_W-1:0] hold_q, hold_d;
  logic             long_q, long_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  // Cleared only on a genuine press (press_d); a bounce back from
  // RELEASE_WAIT keeps the accumulated hold time. Parking at LP_SAT after
  // firing gives at most one pulse per press.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (press_d) begin
      hold_d = '0;
    end else if (state_q == PRESSED) begin
      if (hold_q == LP_LAST) begin
        long_d = 1'b1;
        hold_d = LP_SAT;
      end else if (hold_q != LP_SAT) begin
        hold_d = hold_q + CNT_W'(1);
      end
    end
  end

  assign long_press = long_q;
`else
  assign long_press = 1'b0;
`endif

endmodule
